// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract sequencer: one 3-bit adder slice reused per clock,
// LSB slice first, with the carry chained through a register.

module adder (
  input  logic       cin,
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [3:0] r
);
  assign r = {1'b0, x} + {1'b0, y} + {3'b000, cin};
endmodule

module adder_seq_ctrl #(
  parameter int NSLICE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [3*NSLICE-1:0] a,
  input  logic [3*NSLICE-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [3*NSLICE-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int W  = 3 * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          c_q, c_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cout_q, cout_d, ovf_q, ovf_d;
  logic [2:0]    x_s, y_s;
  logic [3:0]    r_s;
  logic          last_s;

  assign last_s = (idx_q == LAST_IDX);

  // Select the operand slice addressed by idx
  always_comb begin
    x_s = 3'b000;
    y_s = 3'b000;
    for (int i = 0; i < NSLICE; i++) begin
      x_s = (idx_q == IW'(i)) ? a_q[3*i +: 3] : x_s;
      y_s = (idx_q == IW'(i)) ? b_q[3*i +: 3] : y_s;
    end
  end

  adder u_adder (
    .cin (c_q),
    .x   (x_s),
    .y   (y_s),
    .r   (r_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_s ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs (Moore)
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_IDLE:  ready = 1'b1;
      S_RUN:   ready = 1'b0;
      S_DONE:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath next-state: operand latch, slice write-back, flags
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    idx_d  = idx_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B here, inject the +1 as carry-in
          a_d    = a;
          b_d    = b ^ {W{sub}};
          c_d    = sub;
          idx_d  = {IW{1'b0}};
          sum_d  = {W{1'b0}};
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end else begin
          a_d = a_q;
        end
      end
      S_RUN: begin
        c_d   = r_s[3];
        idx_d = idx_q + IW'(1);
        for (int i = 0; i < NSLICE; i++) begin
          sum_d[3*i +: 3] = (idx_q == IW'(i)) ? r_s[2:0] : sum_q[3*i +: 3];
        end
        if (last_s) begin
          cout_d = r_s[3];
          ovf_d  = (a_q[W-1] == b_q[W-1]) && (r_s[2] != a_q[W-1]);
        end else begin
          cout_d = cout_q;
        end
      end
      S_DONE:  c_d = c_q;
      default: c_d = c_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= {W{1'b0}};
      b_q    <= {W{1'b0}};
      c_q    <= 1'b0;
      idx_q  <= {IW{1'b0}};
      sum_q  <= {W{1'b0}};
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      idx_q  <= idx_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (NSLICE=3): scoreboard of expected
// results filled at acceptance and drained on each done pulse.

module tb_adder_seq_ctrl;
  localparam int NSLICE = 3;
  localparam int W      = 3 * NSLICE;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b, sum;
  logic         ready, done, cout, ovf;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   done_cyc1, done_cyc2;

  adder_seq_ctrl #(.NSLICE(NSLICE)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic, signed range check for overflow
  task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    exp_t e;
    int sa, sb_i, sr, ur;
    sa   = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sb_i = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
    sr   = sv ? sa - sb_i : sa + sb_i;
    ur   = sv ? int'(av) - int'(bv) : int'(av) + int'(bv);
    e.s  = W'(ur);
    e.c  = sv ? (av >= bv) : (ur > (1 << W) - 1);
    e.o  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    sb_q.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_sum"},  32'(sum),  32'(e.s));
      chk({tag, "_cout"}, 32'(cout), 32'(e.c));
      chk({tag, "_ovf"},  32'(ovf),  32'(e.o));
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv);
    int lat;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    a = av; b = bv; sub = sv; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; sub = ~sv;
    push_exp(av, bv, sv);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      lat = n;
      if (done) break;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(NSLICE));
    check_result(tag);
    tick();
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_cout",  32'(cout),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);

    do_op("add_ovf", 9'd100, 9'd200, 1'b0);

    // Add wrap with slice-level carry observation
    a = 9'd511; b = 9'd1; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    push_exp(9'd511, 9'd1, 1'b0);
    chk("wrap_busy", 32'(ready), 32'd0);
    tick();
    chk("wrap_slice0", 32'(sum[2:0]), 32'd0);
    chk("wrap_c0", 32'(dut.c_q), 32'd1);
    tick();
    chk("wrap_c1", 32'(dut.c_q), 32'd1);
    tick();
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_c2", 32'(dut.c_q), 32'd1);
    check_result("wrap");
    tick();

    do_op("sub_borrow", 9'd5,   9'd7,   1'b1);
    do_op("sub_ovf",    9'd255, 9'd511, 1'b1);
    do_op("sub_equal",  9'd300, 9'd300, 1'b1);

    // Handshake: start held high, operands disturbed while busy
    a = 9'd10; b = 9'd20; sub = 1'b0; start = 1'b1;
    tick();
    push_exp(9'd10, 9'd20, 1'b0);
    a = 9'd123; b = 9'd456; sub = 1'b1;
    tick();
    chk("hs_run_ready", 32'(ready), 32'd0);
    tick();
    tick();
    chk("hs_done1", 32'(done), 32'd1);
    done_cyc1 = cyc;
    check_result("hs_first");
    a = 9'd40; b = 9'd50; sub = 1'b0;
    tick();
    chk("hs_idle_ready", 32'(ready), 32'd1);
    chk("hs_done_width", 32'(done), 32'd0);
    push_exp(9'd40, 9'd50, 1'b0);
    tick();
    chk("hs_accept2", 32'(ready), 32'd0);
    a = 9'd1; b = 9'd2; sub = 1'b1;
    tick();
    tick();
    tick();
    chk("hs_done2", 32'(done), 32'd1);
    done_cyc2 = cyc;
    chk("hs_gap", 32'(done_cyc2 - done_cyc1), 32'(NSLICE + 2));
    check_result("hs_second");
    start = 1'b0;
    tick();
    chk("hs_done2_width", 32'(done), 32'd0);
    chk("hs_back_idle", 32'(ready), 32'd1);

    // Reset during RUN
    a = 9'd100; b = 9'd50; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_done",  32'(done),  32'd0);
    chk("mid_rst_sum",   32'(sum),   32'd0);
    chk("mid_rst_cout",  32'(cout),  32'd0);
    chk("mid_rst_ovf",   32'(ovf),   32'd0);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("mid_rst_no_done", 32'(done), 32'd0);
    end
    do_op("after_rst", 9'd3, 9'd4, 1'b0);
    chk("after_rst_sum7", 32'(sum), 32'd7);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencer that performs a wide add or subtract by time-multiplexing one instance of the team's 3-bit `adder` slice.
- The slice has ports cin, x[2:0], y[2:0] and r[3:0], with r[3] as carry-out.
- The block latches two NSLICE×3-bit operands and feeds one 3-bit slice per clock, LSB slice first, chaining carry through a register.
- It returns the sum with carry and signed-overflow flags, using a start/done handshake toward the calculator front end.

Parameters:
- NSLICE, 3: number of 3-bit slices. Operand width W = 3*NSLICE (default 9). Legal range 1..8.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; sampled only when ready=1.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  W  operand A; latched with start.
- b  input  W  operand B; latched with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  W  result, modulo 2^W.
- cout  output  1  carry out of the MSB. For subtraction, 1 means no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow of the W-bit result.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; ready=1; done=0; sum=0; cout=0; ovf=0.
  - slice index, carry register and operand registers are cleared.
  - Reset overrides start and aborts any operation in progress; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. On start=1, latch a into A_r, latch b XOR {W{sub}} into B_r, and latch sub. Set carry register c_r=sub, set idx=0, go to RUN.
  - RUN: the adder slice is driven combinationally with x=A_r[3*idx+2:3*idx], y=B_r[3*idx+2:3*idx], cin=c_r. Each edge:
    - write r[2:0] into sum[3*idx+2:3*idx];
    - set c_r <= r[3];
    - set idx <= idx+1.
    - When idx=NSLICE-1, additionally set cout <= r[3] and ovf <= (A_r[W-1]==B_r[W-1]) && (r[2]!=A_r[W-1]), then go to DONE.
  - DONE: done=1 (Moore output, exactly one cycle); next edge goes unconditionally to IDLE. start is ignored in DONE.
- Latency: start is sampled at edge k and done is high during the cycle after edge k+NSLICE (default 3). Throughput is one operation per NSLICE+2 cycles.
- start while ready=0 is ignored and is not queued. Operand and sub changes outside the accepting edge have no effect.
- sum/cout/ovf while busy and between operations:
  - sum is cleared to 0 on the accepting edge and is filled slice by slice during RUN.
  - Bench checks sum only when done=1.
  - sum, cout and ovf then hold their values until the next accepted start or reset.
  - cout and ovf are cleared on the accepting edge.
- start held continuously high begins a new operation on the first IDLE cycle after DONE.
- Width rules:
  - Arithmetic wraps modulo 2^W; no saturation.
  - idx width is clog2(NSLICE), minimum 1 bit.
  - With NSLICE=1, RUN lasts exactly one cycle.
- The block contains exactly one adder instance; no other adder logic on the sum path.

Test Plan (NSLICE=3, W=9):
- Add overflow: reset, then start with a=100, b=200, sub=0 → done 3 edges after acceptance; sum=300 (0x12C), cout=0, ovf=1; ready returns 1 the following cycle.
- Add wrap: a=511, b=1, sub=0 → sum=0, cout=1, ovf=0. Also check the intermediate slices: sum[2:0]=0 after the 1st RUN edge, c_r=1 through all slices.
- Subtract with borrow: a=5, b=7, sub=1 → sum=510 (0x1FE), cout=0, ovf=0.
- Subtract overflow: a=255, b=511 (-1), sub=1 → sum=256, cout=0, ovf=1.
- Subtract equal operands: a=300, b=300, sub=1 → sum=0, cout=1, ovf=0.
- Handshake: hold start=1 continuously and change a/b during RUN →
  - the first result uses the operands latched at the accepting edge;
  - start pulses during RUN/DONE are ignored;
  - a second operation is accepted on the IDLE cycle right after DONE;
  - done pulses are exactly 1 cycle wide, NSLICE+2 cycles apart.
- Reset mid-op: assert rst at the 2nd RUN edge → next cycle ready=1, done=0, sum=0, cout=0, ovf=0; no done pulse occurs; a fresh start of 3+4 then gives sum=7.
